// File: rtl/noc_sched_pkg.sv
// Shared state encoding, descriptor layout and round-robin pick for the NoC write scheduler.
package noc_sched_pkg;

  typedef enum logic [1:0] {
    IDLE,
    INIT,
    DATA,
    WAIT_DONE
  } sched_state_e;

  typedef struct packed {
    logic [7:0]  port_id;
    logic [31:0] len;
    logic [31:0] addr;
  } sched_desc_t;

  // First set bit of req_mask after 'last', wrapping within n requesters (n <= 8).
  function automatic logic [2:0] rr_pick(input logic [7:0]  req_mask,
                                         input logic [2:0]  last,
                                         input int unsigned n);
    logic [2:0] pick;
    logic [2:0] idx;
    logic       found;
    pick  = '0;
    found = 1'b0;
    for (int unsigned k = 1; k <= 8; k++) begin
      idx = 3'((32'(last) + k) % n);
      if (!found && (k <= n) && req_mask[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/sched_desc_fifo.sv
// Per-source descriptor queue; the head is presented combinationally so a pop
// in the same cycle as a push still returns the older entry.
module sched_desc_fifo
  import noc_sched_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        push_i,
  input  logic        pop_i,
  input  sched_desc_t din_i,
  output sched_desc_t dout_o,
  output logic        full_o,
  output logic        empty_o
);

  localparam int AW = $clog2(DEPTH);

  sched_desc_t mem_q [DEPTH];
  logic [AW:0] wr_ptr_q;
  logic [AW:0] rd_ptr_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_i && !full_o) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (pop_i && !empty_o) rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i && !full_o) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
  end

  assign dout_o  = mem_q[rd_ptr_q[AW-1:0]];
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

endmodule

// File: rtl/noc_wr_scheduler.sv
// Round-robin write-message scheduler feeding the AXI NoC master.
//   IDLE      | waiting for any queued descriptor; grants and pops on exit
//   INIT      | INIT_AXI_TXN pulse toward the master
//   DATA      | streaming the granted source's beats
//   WAIT_DONE | all beats sent, waiting for TXN_DONE
module noc_wr_scheduler
  import noc_sched_pkg::*;
#(
  parameter int NUM_SRC    = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_LEN    = 16,
  parameter int INIT_PULSE = 4
) (
  input  logic                       M_AXI_ACLK,
  input  logic                       M_AXI_ARESET,
  input  logic [NUM_SRC-1:0]         S_REQ_VALID,
  output logic [NUM_SRC-1:0]         S_REQ_READY,
  input  logic [8*NUM_SRC-1:0]       S_REQ_PORT_ID,
  input  logic [32*NUM_SRC-1:0]      S_REQ_LEN,
  input  logic [32*NUM_SRC-1:0]      S_REQ_ADDR,
  input  logic [32*NUM_SRC-1:0]      S_DATA,
  input  logic [NUM_SRC-1:0]         S_DATA_VALID,
  output logic [NUM_SRC-1:0]         S_DATA_READY,
  input  logic                       WDATA_READY,
  input  logic                       TXN_DONE,
  output logic                       INIT_AXI_TXN,
  output logic [7:0]                 PORT_ID_WR,
  output logic [31:0]                MSG_LENGTH_WR,
  output logic [31:0]                INPUT_WADDR,
  output logic [31:0]                INPUT_WDATA,
  output logic [$clog2(NUM_SRC)-1:0] GRANT_ID,
  output logic                       BUSY,
  output logic [NUM_SRC-1:0]         LEN_ERR
);

  localparam int GW = $clog2(NUM_SRC);
  localparam int BW = $clog2(MAX_LEN) + 1;
  localparam int IW = $clog2(INIT_PULSE + 1);

  sched_desc_t        fifo_din  [NUM_SRC];
  sched_desc_t        fifo_dout [NUM_SRC];
  logic [NUM_SRC-1:0] fifo_full;
  logic [NUM_SRC-1:0] fifo_empty;
  logic [NUM_SRC-1:0] fifo_push;
  logic [NUM_SRC-1:0] fifo_pop;
  logic [NUM_SRC-1:0] len_ok;
  logic [NUM_SRC-1:0] req_acc;

  sched_state_e       state_q, state_d;
  logic [GW-1:0]      grant_q, grant_d;
  logic [GW-1:0]      last_q, last_d;
  logic [7:0]         port_q, port_d;
  logic [31:0]        len_q, len_d;
  logic [31:0]        addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [BW-1:0]      beat_q, beat_d;
  logic [IW-1:0]      icnt_q, icnt_d;
  logic               init_q, init_d;
  logic [NUM_SRC-1:0] lerr_q;

  logic [GW-1:0]      pick;
  logic               xfer;
  sched_desc_t        head;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    assign fifo_din[i] = '{port_id: S_REQ_PORT_ID[8*i +: 8],
                           len:     S_REQ_LEN[32*i +: 32],
                           addr:    S_REQ_ADDR[32*i +: 32]};
    // Bad lengths are handshaken away so a source never stalls on them.
    assign len_ok[i]    = (S_REQ_LEN[32*i +: 32] != '0) &&
                          (S_REQ_LEN[32*i +: 32] <= 32'(MAX_LEN));
    assign req_acc[i]   = S_REQ_VALID[i] & ~fifo_full[i];
    assign fifo_push[i] = req_acc[i] & len_ok[i];

    sched_desc_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk_i   (M_AXI_ACLK),
      .rst_i   (M_AXI_ARESET),
      .push_i  (fifo_push[i]),
      .pop_i   (fifo_pop[i]),
      .din_i   (fifo_din[i]),
      .dout_o  (fifo_dout[i]),
      .full_o  (fifo_full[i]),
      .empty_o (fifo_empty[i])
    );
  end

  assign S_REQ_READY = ~fifo_full;
  assign pick        = GW'(rr_pick(8'(~fifo_empty), 3'(last_q), NUM_SRC));
  assign head        = fifo_dout[pick];
  assign xfer        = (state_q == DATA) && S_DATA_VALID[grant_q] && WDATA_READY;

  always_comb begin
    S_DATA_READY = '0;
    if (state_q == DATA) S_DATA_READY[grant_q] = WDATA_READY;
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    last_d   = last_q;
    port_d   = port_q;
    len_d    = len_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    beat_d   = beat_q;
    icnt_d   = icnt_q;
    init_d   = 1'b0;
    fifo_pop = '0;
    case (state_q)
      IDLE: begin
        if (|(~fifo_empty)) begin
          fifo_pop[pick] = 1'b1;
          grant_d        = pick;
          port_d         = head.port_id;
          len_d          = head.len;
          addr_d         = head.addr;
          beat_d         = head.len[BW-1:0];
          icnt_d         = IW'(INIT_PULSE);
          state_d        = INIT;
        end
      end
      INIT: begin
        if (icnt_q != '0) begin
          init_d = 1'b1;
          icnt_d = icnt_q - 1'b1;
        end else begin
          state_d = DATA;
        end
      end
      DATA: begin
        if (xfer) begin
          wdata_d = S_DATA[32*grant_q +: 32];
          beat_d  = beat_q - 1'b1;
          if (beat_q == BW'(1)) state_d = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (TXN_DONE) begin
          last_d  = grant_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge M_AXI_ACLK) begin
    if (M_AXI_ARESET) begin
      state_q <= IDLE;
      grant_q <= '0;
      last_q  <= GW'(NUM_SRC - 1);
      port_q  <= '0;
      len_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      beat_q  <= '0;
      icnt_q  <= '0;
      init_q  <= 1'b0;
      lerr_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      port_q  <= port_d;
      len_q   <= len_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      beat_q  <= beat_d;
      icnt_q  <= icnt_d;
      init_q  <= init_d;
      lerr_q  <= req_acc & ~len_ok;
    end
  end

  assign INIT_AXI_TXN  = init_q;
  assign PORT_ID_WR    = port_q;
  assign MSG_LENGTH_WR = len_q;
  assign INPUT_WADDR   = addr_q;
  assign INPUT_WDATA   = wdata_q;
  assign GRANT_ID      = grant_q;
  assign BUSY          = (state_q != IDLE);
  assign LEN_ERR       = lerr_q;

endmodule

// File: tb/tb_noc_wr_scheduler.sv
// Self-checking bench: transaction-level model of queues, round-robin and timing.
module tb_noc_wr_scheduler;

  localparam int NS    = 4;
  localparam int DEPTH = 4;
  localparam int MAXL  = 16;
  localparam int P     = 4;

  typedef struct {
    logic [7:0]  port;
    logic [31:0] len;
    logic [31:0] addr;
    logic [31:0] base;
  } req_t;

  logic            clk = 1'b0;
  logic            rst;
  logic [NS-1:0]   req_valid, req_ready, sdata_valid, sdata_ready, len_err;
  logic [8*NS-1:0] req_port;
  logic [32*NS-1:0] req_len, req_addr, sdata;
  logic            wready, txn_done, init, busy;
  logic [7:0]      port_id;
  logic [31:0]     msg_len, waddr, wdata;
  logic [1:0]      grant_id;

  always #5 clk = ~clk;

  noc_wr_scheduler #(.NUM_SRC(NS), .FIFO_DEPTH(DEPTH), .MAX_LEN(MAXL), .INIT_PULSE(P)) dut (
    .M_AXI_ACLK   (clk),
    .M_AXI_ARESET (rst),
    .S_REQ_VALID  (req_valid),
    .S_REQ_READY  (req_ready),
    .S_REQ_PORT_ID(req_port),
    .S_REQ_LEN    (req_len),
    .S_REQ_ADDR   (req_addr),
    .S_DATA       (sdata),
    .S_DATA_VALID (sdata_valid),
    .S_DATA_READY (sdata_ready),
    .WDATA_READY  (wready),
    .TXN_DONE     (txn_done),
    .INIT_AXI_TXN (init),
    .PORT_ID_WR   (port_id),
    .MSG_LENGTH_WR(msg_len),
    .INPUT_WADDR  (waddr),
    .INPUT_WDATA  (wdata),
    .GRANT_ID     (grant_id),
    .BUSY         (busy),
    .LEN_ERR      (len_err)
  );

  req_t        pend [NS][$];
  req_t        mq   [NS][$];
  logic [31:0] dq   [NS][$];
  logic [1:0]  obs_g[$];

  bit          m_active;
  int          m_g, m_last, m_gcyc, m_beats, ecyc;
  req_t        m_cur;
  logic [31:0] m_wdata;
  logic [NS-1:0] m_lerr;
  bit          wr_rand, dv_rand, done_spur, prev_busy;
  int          n_cmp, n_bad;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h (edge %0d)", tag, obs, exp, ecyc);
    end
  endtask

  task automatic add_req(input int k, input logic [7:0] port, input logic [31:0] len,
                         input logic [31:0] addr, input logic [31:0] base);
    req_t r;
    r.port = port; r.len = len; r.addr = addr; r.base = base;
    pend[k].push_back(r);
  endtask

  function automatic int rr_model();
    for (int i = 1; i <= NS; i++) begin
      int idx;
      idx = (m_last + i) % NS;
      if (mq[idx].size() > 0) return idx;
    end
    return -1;
  endfunction

  function automatic bit pending();
    for (int k = 0; k < NS; k++)
      if (pend[k].size() > 0 || mq[k].size() > 0) return 1'b1;
    return m_active;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < NS; k++) mq[k].delete();
    m_active = 1'b0; m_last = NS - 1; m_g = 0; m_beats = 0; m_wdata = '0; m_lerr = '0;
    m_cur.port = '0; m_cur.len = '0; m_cur.addr = '0; m_cur.base = '0;
  endtask

  task automatic drive();
    for (int k = 0; k < NS; k++) begin
      req_valid[k]          = (pend[k].size() > 0);
      req_port[8*k +: 8]    = (pend[k].size() > 0) ? pend[k][0].port : 8'h0;
      req_len[32*k +: 32]   = (pend[k].size() > 0) ? pend[k][0].len  : 32'h0;
      req_addr[32*k +: 32]  = (pend[k].size() > 0) ? pend[k][0].addr : 32'h0;
      sdata[32*k +: 32]     = (dq[k].size() > 0) ? dq[k][0] : 32'h0;
      sdata_valid[k]        = (dq[k].size() > 0) && (!dv_rand || $urandom_range(0, 1) == 1);
    end
    wready   = !wr_rand || ($urandom_range(0, 2) == 0);
    txn_done = ((m_active && m_beats == int'(m_cur.len)) || done_spur) && ($urandom_range(0, 2) == 0);
  endtask

  task automatic check_outputs();
    int            rel;
    bit            dph;
    logic [NS-1:0] rdy;
    rel = ecyc - m_gcyc;
    dph = m_active && rel >= P + 1 && m_beats < int'(m_cur.len);
    for (int k = 0; k < NS; k++) rdy[k] = (mq[k].size() < DEPTH);
    chk("busy",       busy,        m_active);
    chk("init",       init,        m_active && rel >= 1 && rel <= P);
    chk("grant_id",   grant_id,    m_g);
    chk("port_id",    port_id,     m_cur.port);
    chk("msg_len",    msg_len,     m_cur.len);
    chk("waddr",      waddr,       m_cur.addr);
    chk("wdata",      wdata,       m_wdata);
    chk("len_err",    len_err,     m_lerr);
    chk("req_ready",  req_ready,   rdy);
    chk("data_ready", sdata_ready, dph ? (NS'(wready) << m_g) : '0);
    if (busy && !prev_busy) obs_g.push_back(grant_id);
    prev_busy = busy;
  endtask

  task automatic tick();
    logic [NS-1:0] acc;
    bit xf, dn, gr;
    int rel, gi;
    req_t r;
    rel = ecyc - m_gcyc;
    xf  = m_active && rel >= P + 1 && m_beats < int'(m_cur.len) && sdata_valid[m_g] && wready;
    dn  = m_active && m_beats == int'(m_cur.len) && txn_done;
    gr  = !m_active;
    for (int k = 0; k < NS; k++) acc[k] = req_valid[k] && (mq[k].size() < DEPTH);
    @(posedge clk);
    #1;
    ecyc++;
    if (rst) begin
      model_reset();
    end else begin
      if (xf) begin
        m_beats++;
        m_wdata = dq[m_g].pop_front();
      end
      if (dn) begin
        m_active = 1'b0;
        m_last   = m_g;
      end
      if (gr) begin
        gi = rr_model();
        if (gi >= 0) begin
          m_g = gi; m_cur = mq[gi].pop_front();
          m_active = 1'b1; m_gcyc = ecyc; m_beats = 0;
        end
      end
      for (int k = 0; k < NS; k++) begin
        m_lerr[k] = 1'b0;
        if (acc[k]) begin
          r = pend[k].pop_front();
          if (r.len != 0 && r.len <= MAXL) begin
            mq[k].push_back(r);
            for (int j = 0; j < int'(r.len); j++) dq[k].push_back(r.base + j);
          end else begin
            m_lerr[k] = 1'b1;
          end
        end
      end
    end
    check_outputs();
    @(negedge clk);
    drive();
  endtask

  task automatic drain(input int bound);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (n < bound && (pending() || busy));
    chk("drain_busy", busy, 1'b0);
  endtask

  task automatic do_reset();
    for (int k = 0; k < NS; k++) begin
      pend[k].delete();
      dq[k].delete();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  int          exp_order [7] = '{0, 1, 2, 3, 0, 1, 0};
  int          ng, n;
  logic [31:0] b6;

  initial begin
    rst = 1'b1; req_valid = '0; req_port = '0; req_len = '0; req_addr = '0;
    sdata = '0; sdata_valid = '0; wready = 1'b1; txn_done = 1'b0;
    n_cmp = 0; n_bad = 0; ecyc = 0; m_gcyc = 0; prev_busy = 1'b0;
    wr_rand = 1'b0; dv_rand = 1'b0; done_spur = 1'b0;
    model_reset();
    @(negedge clk);
    tick();
    chk("rst_ready", req_ready, 4'hF);
    chk("rst_busy", busy, 1'b0);
    rst = 1'b0;

    // single descriptor on src1
    add_req(1, 8'd2, 32'd5, 32'h100, 32'd0);
    drain(200);
    chk("t1_ngrants", obs_g.size(), 1);
    if (obs_g.size() > 0) chk("t1_grant", obs_g[0], 1);
    chk("t1_last_wdata", wdata, 4);

    // round-robin across all sources, then src1 before a repeat of src0
    do_reset();
    obs_g.delete();
    for (int k = 0; k < NS; k++) add_req(k, 8'(k + 8), 32'd16, 32'h1000 * k, 32'h100 * k);
    drain(1000);
    add_req(0, 8'd40, 32'd3, 32'h40, 32'hA0);
    repeat (4) tick();
    add_req(0, 8'd41, 32'd2, 32'h44, 32'hB0);
    add_req(1, 8'd42, 32'd2, 32'h48, 32'hC0);
    drain(500);
    chk("t2_ngrants", obs_g.size(), 7);
    for (int i = 0; i < obs_g.size() && i < 7; i++)
      chk($sformatf("t2_grant%0d", i), obs_g[i], exp_order[i]);

    // randomized backpressure, data stalls and spurious TXN_DONE
    wr_rand = 1'b1; dv_rand = 1'b1; done_spur = 1'b1;
    for (int i = 0; i < 6; i++)
      add_req($urandom_range(0, NS - 1), 8'($urandom), 32'($urandom_range(1, MAXL)), $urandom, $urandom);
    drain(3000);
    wr_rand = 1'b0; dv_rand = 1'b0; done_spur = 1'b0;

    // src2 fills; sixth descriptor waits on READY
    for (int i = 0; i < 6; i++) add_req(2, 8'(i), 32'd3, 32'h200 + i, 32'h500 + 16 * i);
    repeat (8) tick();
    chk("t4_src2_full", req_ready[2], 1'b0);
    drain(500);

    // illegal lengths are dropped
    ng = obs_g.size();
    add_req(3, 8'd9, 32'd0, 32'h300, 32'h0);
    add_req(0, 8'd9, 32'd17, 32'h304, 32'h0);
    drain(50);
    chk("t5_no_grant", obs_g.size(), ng);

    // reset in the middle of an 8-beat message
    b6 = 32'h7700;
    add_req(1, 8'd5, 32'd8, 32'h600, b6);
    add_req(2, 8'd6, 32'd4, 32'h700, 32'h8800);
    n = 0;
    while (!(m_active && m_beats == 3) && n < 100) begin
      tick();
      n++;
    end
    chk("t6_beat3", wdata, b6 + 2);
    do_reset();
    chk("t6_busy", busy, 1'b0);
    chk("t6_wdata", wdata, 0);
    chk("t6_msglen", msg_len, 0);
    chk("t6_ready", req_ready, 4'hF);
    ng = obs_g.size();
    done_spur = 1'b1;
    repeat (20) tick();
    done_spur = 1'b0;
    chk("t6_no_grant", obs_g.size(), ng);
    chk("t6_idle", busy, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
